acc_program_sequencer: RTL and testbench

//  Program sequencer for the 8-bit ALU/accumulator datapath (instruction register + ALU + accumulator).

---
 rtl/acc_program_sequencer.sv | 167 ++++++++++++++++
 tb/tb_acc_program_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_program_sequencer.sv
// Program sequencer for the 8-bit ALU/accumulator datapath.
// Holds a small program memory and a program counter, and steps each
// instruction through FETCH -> DECODE -> EXECUTE, driving the fetch,
// IR-load and accumulator-load strobes. Supports halt, conditional and
// unconditional branches, pc wrap-around and a saturating retired-op counter.
//
// Handshake: there is no valid/ready pair here. start and prog_we are
// level-sampled request strobes. They are accepted on the rising edge only
// while the sequencer is in IDLE or HALT, and are ignored in every other state.
//
// Program word layout: [12:11] ctrl, [10:8] ALU opcode, [7:0] literal.
//   ctrl 00 = ALU op, 01 = halt, 10 = branch if acc_value==0, 11 = branch always.
//
// dbg_state encoding: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXECUTE, 4 HALT.
module acc_program_sequencer #(
    parameter int PC_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prog_we,
    input  logic [PC_W-1:0]  prog_addr,
    input  logic [12:0]      prog_wdata,
    input  logic             start,
    input  logic [7:0]       acc_value,
    output logic [10:0]      instr,
    output logic             fetch,
    output logic             ir_load,
    output logic             acc_load,
    output logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       dbg_state
);

    localparam int DEPTH = 1 << PC_W;

    localparam logic [1:0] CTRL_ALU    = 2'b00;
    localparam logic [1:0] CTRL_HALT   = 2'b01;
    localparam logic [1:0] CTRL_BR_Z   = 2'b10;
    localparam logic [1:0] CTRL_BR_ALL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [10:0]      instr_q, instr_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             mem_we;
    logic [12:0]      word;
    logic [12:0]      mem [DEPTH];

    // Program memory: written only when the sequencer is parked; never cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    // Combinational read of the word addressed by the current program counter.
    assign word = mem[pc_q];

    // State, program counter, instruction latch and retired counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic: sequencing, branch resolution, pc advance and counter update.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        mem_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A write in the same cycle as start lands before the first fetch reads it.
                mem_we = prog_we;
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                instr_d = word[10:0];
                case (word[12:11])
                    CTRL_ALU: begin
                        state_d = S_DECODE;
                    end
                    CTRL_HALT: begin
                        state_d = S_HALT;
                    end
                    CTRL_BR_Z: begin
                        if (acc_value == 8'd0) begin
                            pc_d = word[PC_W-1:0];
                        end else begin
                            pc_d = pc_q + PC_W'(1);
                        end
                    end
                    CTRL_BR_ALL: begin
                        pc_d = word[PC_W-1:0];
                    end
                    default: begin
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_DECODE: begin
                state_d = S_EXECUTE;
            end

            S_EXECUTE: begin
                // The pc wraps naturally at 2**PC_W-1 because of its width.
                pc_d = pc_q + PC_W'(1);
                if (retired_q != {CNT_W{1'b1}}) begin
                    retired_d = retired_q + CNT_W'(1);
                end
                state_d = S_FETCH;
            end

            S_HALT: begin
                mem_we = prog_we;
                if (start) begin
                    pc_d      = '0;
                    retired_d = '0;
                    state_d   = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All outputs decode purely from registered state, so the strobes are glitch-free.
    assign fetch     = (state_q == S_FETCH);
    assign ir_load   = (state_q == S_DECODE);
    assign acc_load  = (state_q == S_EXECUTE);
    assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXECUTE);
    assign halted    = (state_q == S_HALT);
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign retired   = retired_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_acc_program_sequencer.sv
// Bench for acc_program_sequencer: an attached accumulator datapath plus an
// instruction-level reference model that predicts every cycle's outputs.
module tb_acc_program_sequencer;

    logic        clk;
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [12:0] prog_wdata;
    logic        start;
    logic [7:0]  acc;

    logic [10:0] instr;
    logic        fetch, ir_load, acc_load, busy, halted;
    logic [3:0]  pc;
    logic [15:0] retired;
    logic [2:0]  dbg_state;

    logic [10:0] s_instr;
    logic        s_fetch, s_ir_load, s_acc_load, s_busy, s_halted;
    logic [3:0]  s_pc;
    logic [2:0]  s_retired;
    logic [2:0]  s_dbg_state;

    logic        acc_set;
    logic [7:0]  acc_set_val;
    logic [10:0] ir;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference-model state (instruction level)
    logic [12:0] prog [16];
    int          m_pc, m_exec;
    logic [10:0] m_instr;
    logic [7:0]  m_acc;

    // Run control
    string cur_tag;
    int    cyc, max_cyc, poke_we, poke_st;
    bit    stopped, hflag;

    acc_program_sequencer #(.PC_W(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .acc_value(acc),
        .instr(instr), .fetch(fetch), .ir_load(ir_load), .acc_load(acc_load),
        .pc(pc), .busy(busy), .halted(halted), .retired(retired), .dbg_state(dbg_state)
    );

    // Narrow-counter instance sharing the same stimulus, used to reach saturation quickly
    acc_program_sequencer #(.PC_W(4), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .acc_value(acc),
        .instr(s_instr), .fetch(s_fetch), .ir_load(s_ir_load), .acc_load(s_acc_load),
        .pc(s_pc), .busy(s_busy), .halted(s_halted), .retired(s_retired), .dbg_state(s_dbg_state)
    );

    function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] lit);
        case (op)
            3'd0:    return a + lit;
            3'd1:    return a - lit;
            3'd2:    return a & lit;
            3'd3:    return a | lit;
            3'd4:    return lit;
            3'd5:    return a ^ lit;
            3'd6:    return {a[6:0], 1'b0};
            default: return a;
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached datapath: IR and accumulator driven by the sequencer strobes
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 8'd0;
            ir  <= 11'd0;
        end else begin
            if (ir_load) ir <= instr;
            if (acc_set) acc <= acc_set_val;
            else if (acc_load) acc <= alu(ir[10:8], acc, ir[7:0]);
        end
    end

    task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Compare one cycle against the model, optionally poke inputs, then advance to the next negedge
    task automatic expect_cycle(input bit f, input bit d, input bit e, input bit h);
        string p;
        if (stopped) return;
        p = $sformatf("%s.c%0d", cur_tag, cyc);
        chk({p, ".fetch"},    32'(fetch),     32'(f));
        chk({p, ".ir_load"},  32'(ir_load),   32'(d));
        chk({p, ".acc_load"}, 32'(acc_load),  32'(e));
        chk({p, ".busy"},     32'(busy),      32'(f | d | e));
        chk({p, ".halted"},   32'(halted),    32'(h));
        chk({p, ".pc"},       32'(pc),        32'(m_pc));
        chk({p, ".instr"},    32'(instr),     32'(m_instr));
        chk({p, ".retired"},  32'(retired),   32'(sat(m_exec, 65535)));
        chk({p, ".s_retired"},32'(s_retired), 32'(sat(m_exec, 7)));
        chk({p, ".acc"},      32'(acc),       32'(m_acc));
        if (cyc == max_cyc) begin
            stopped = 1'b1;
            return;
        end
        if (!h && cyc == poke_we) begin
            prog_we    = 1'b1;
            prog_addr  = 4'd1;
            prog_wdata = 13'h1fff;
        end
        if (!h && cyc == poke_st) start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0;
        start   = 1'b0;
        cyc++;
    endtask

    task automatic write_word(input int a, input logic [12:0] w);
        prog_we    = 1'b1;
        prog_addr  = a[3:0];
        prog_wdata = w;
        @(negedge clk);
        prog_we = 1'b0;
        prog[a] = w;
    endtask

    task automatic set_acc(input logic [7:0] v);
        acc_set     = 1'b1;
        acc_set_val = v;
        @(negedge clk);
        acc_set = 1'b0;
        m_acc   = v;
    endtask

    // Start the program and follow it instruction by instruction until halt or the cycle limit
    task automatic run(input string t, input int max_c, input int we_c, input int st_c);
        logic [12:0] w;
        cur_tag = t; max_cyc = max_c; poke_we = we_c; poke_st = st_c;
        stopped = 1'b0; hflag = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cyc    = 1;
        m_pc   = 0;
        m_exec = 0;
        while (!stopped && !hflag) begin
            w = prog[m_pc];
            expect_cycle(1, 0, 0, 0);
            m_instr = w[10:0];
            case (w[12:11])
                2'b00: begin
                    expect_cycle(0, 1, 0, 0);
                    expect_cycle(0, 0, 1, 0);
                    m_acc  = alu(w[10:8], m_acc, w[7:0]);
                    m_exec = m_exec + 1;
                    m_pc   = (m_pc + 1) % 16;
                end
                2'b01: begin
                    expect_cycle(0, 0, 0, 1);
                    hflag = 1'b1;
                end
                2'b10: m_pc = (m_acc == 8'd0) ? int'(w[3:0]) : (m_pc + 1) % 16;
                default: m_pc = int'(w[3:0]);
            endcase
        end
    endtask

    // Assert reset between clock edges and check every output drops at once
    task automatic reset_check(input string t);
        #2 rst_n = 1'b0;
        #1;
        chk({t, ".fetch"},    32'(fetch),     0);
        chk({t, ".ir_load"},  32'(ir_load),   0);
        chk({t, ".acc_load"}, 32'(acc_load),  0);
        chk({t, ".busy"},     32'(busy),      0);
        chk({t, ".halted"},   32'(halted),    0);
        chk({t, ".pc"},       32'(pc),        0);
        chk({t, ".instr"},    32'(instr),     0);
        chk({t, ".retired"},  32'(retired),   0);
        chk({t, ".state"},    32'(dbg_state), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_pc    = 0;
        m_instr = '0;
        m_exec  = 0;
        m_acc   = 8'd0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        start = 1'b0; acc_set = 1'b0; acc_set_val = '0;
        for (int i = 0; i < 16; i++) prog[i] = 13'h0800;
        m_pc = 0; m_instr = '0; m_exec = 0; m_acc = '0;
        repeat (2) @(negedge clk);
        chk("reset.busy",  32'(busy), 0);
        chk("reset.state", 32'(dbg_state), 0);
        rst_n = 1'b1;
        // Clear both program memories to halts so random runs start from known words
        for (int i = 0; i < 16; i++) write_word(i, 13'h0800);

        // Load 5, add 3, halt
        write_word(0, 13'h0405);
        write_word(1, 13'h0003);
        write_word(2, 13'h0800);
        run("t2", 100, -1, -1);
        chk("t2.acc_final",  32'(acc), 32'h08);
        chk("t2.ret_final",  32'(retired), 2);
        chk("t2.pc_final",   32'(pc), 2);

        // Restart from HALT after rewriting word 0
        write_word(0, 13'h042a);
        run("t6", 100, -1, -1);
        chk("t6.acc_final", 32'(acc), 32'h2d);

        // Write and start attempts while busy are ignored
        write_word(0, 13'h0405);
        run("t5", 100, 2, 5);
        run("t5b", 100, -1, -1);

        // Reset mid-EXECUTE, then rerun from IDLE with memory intact
        run("t1", 3, -1, -1);
        chk("t1.in_exec", 32'(acc_load), 1);
        reset_check("t1.rst");
        run("t1b", 100, -1, -1);

        // Conditional branch taken and not taken
        write_word(0, 13'h1003);
        write_word(3, 13'h0800);
        set_acc(8'd0);
        run("t3a", 100, -1, -1);
        chk("t3a.pc_final", 32'(pc), 3);
        chk("t3a.ret_final", 32'(retired), 0);
        write_word(1, 13'h0800);
        set_acc(8'd1);
        run("t3b", 100, -1, -1);
        chk("t3b.pc_final", 32'(pc), 1);

        // Sixteen ALU ops: pc wraps, narrow counter saturates
        reset_check("t4.rst0");
        for (int i = 0; i < 16; i++) write_word(i, {2'b00, 3'($urandom_range(0, 7)), 8'($urandom)});
        run("t4", 16 * 3 + 10, -1, -1);
        reset_check("t4.rst1");

        // Randomized programs with busy-time pokes and reset mid-run
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) begin
                int          sel;
                logic [1:0]  c;
                sel = $urandom_range(0, 99);
                c = (sel < 60) ? 2'b00 : (sel < 70) ? 2'b01 : (sel < 85) ? 2'b10 : 2'b11;
                write_word(i, {c, 3'($urandom_range(0, 7)), 8'($urandom)});
            end
            set_acc(($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom));
            run($sformatf("rnd%0d", r), 50, $urandom_range(2, 20), $urandom_range(2, 20));
            reset_check($sformatf("rnd%0d.rst", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
